uart_tx_cfg: RTL and testbench

//   Parametrised UART transmitter, successor to the fixed 8N1+parity TX.

---
 rtl/uart_tx_cfg.sv | 216 +++++++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_cfg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_tx_cfg                                                   |
// | Purpose  : Parametrised UART transmitter. DBIT data bits (LSB first),    |
// |            OVS s_tick pulses per bit, run-time parity (none/even/odd/    |
// |            mark) and one or two stop bits, latched at frame load.        |
// |            Ready/valid input handshake.                                  |
// | Option   : define UART_TX_FIFO_EN to put a FIFO_DEPTH-entry input FIFO   |
// |            (power of two, >= 2) in front of the engine. Without it a     |
// |            word is accepted only while the engine is idle.               |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module uart_tx_cfg #(
  parameter int DBIT       = 8,
  parameter int OVS        = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            s_tick,
  input  logic [DBIT-1:0] din,
  input  logic            din_valid,
  output logic            din_ready,
  input  logic [1:0]      cfg_par,
  input  logic            cfg_stop2,
  output logic            tx,
  output logic            busy,
  output logic            tx_done_tick
);

  // Tick counter must reach 2*OVS-1 for a double stop bit.
  localparam int c_TW = $clog2(2 * OVS);
  localparam int c_BW = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [c_TW-1:0] c_TICK_LAST  = c_TW'(OVS - 1);
  localparam logic [c_TW-1:0] c_STOP2_LAST = c_TW'(2 * OVS - 1);
  localparam logic [c_TW-1:0] c_TICK_ONE   = c_TW'(1);
  localparam logic [c_BW-1:0] c_BIT_LAST   = c_BW'(DBIT - 1);
  localparam logic [c_BW-1:0] c_BIT_ONE    = c_BW'(1);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_START  = 3'd1;
  localparam logic [2:0] c_DATA   = 3'd2;
  localparam logic [2:0] c_PARITY = 3'd3;
  localparam logic [2:0] c_STOP   = 3'd4;

  logic [2:0]      r_state;
  logic [2:0]      w_state_next;
  logic [c_TW-1:0] r_tick;
  logic [c_BW-1:0] r_bit;
  logic [DBIT-1:0] r_shreg;
  logic            r_par_bit;
  logic            r_par_en;
  logic            r_stop2;
  logic            r_tx;
  logic            w_tx_next;

  logic            w_avail;     // a word is waiting for the engine
  logic [DBIT-1:0] w_word;      // the word the engine would take now
  logic            w_load;      // engine takes w_word this clk
  logic            w_par_calc;
  logic [c_TW-1:0] w_stop_last;
  logic            w_period_end;

  assign w_load = (r_state == c_IDLE) && w_avail;

`ifdef UART_TX_FIFO_EN
  localparam int              c_AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [c_AW:0]   c_DEPTH = (c_AW + 1)'(FIFO_DEPTH);
  localparam logic [c_AW:0]   c_CNT_ONE = (c_AW + 1)'(1);
  localparam logic [c_AW-1:0] c_PTR_ONE = c_AW'(1);

  logic [DBIT-1:0] r_mem [FIFO_DEPTH];
  logic [c_AW-1:0] r_wp;
  logic [c_AW-1:0] r_rp;
  logic [c_AW:0]   r_count;
  logic            w_push;
  logic            w_full;

  assign w_full    = (r_count == c_DEPTH);
  assign din_ready = !w_full;
  assign w_push    = din_valid && !w_full;
  assign w_avail   = (r_count != '0);
  assign w_word    = r_mem[r_rp];

  // FIFO storage: data only, no reset needed
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wp] <= din;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wp <= r_wp + c_PTR_ONE;
      end
      if (w_load) begin
        r_rp <= r_rp + c_PTR_ONE;
      end
      case ({w_push, w_load})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end
`else
  // Direct path: FIFO_DEPTH is meaningless here and always satisfied.
  localparam bit c_DIRECT = (FIFO_DEPTH >= 0);

  assign din_ready = (r_state == c_IDLE) && c_DIRECT;
  assign w_avail   = din_valid;
  assign w_word    = din;
`endif

  // Parity is taken from the word being loaded and frozen for the frame
  always_comb begin
    w_par_calc = 1'b0;
    case (cfg_par)
      2'b01:   w_par_calc = ^w_word;
      2'b10:   w_par_calc = ~^w_word;
      2'b11:   w_par_calc = 1'b1;
      default: w_par_calc = 1'b0;
    endcase
  end

  assign w_stop_last  = r_stop2 ? c_STOP2_LAST : c_TICK_LAST;
  assign w_period_end = s_tick &&
                        ((r_state == c_STOP) ? (r_tick == w_stop_last)
                                             : (r_tick == c_TICK_LAST));

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; every transition out of a bit state waits for its last tick
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_IDLE:   if (w_load)       w_state_next = c_START;
      c_START:  if (w_period_end) w_state_next = c_DATA;
      c_DATA:   if (w_period_end && (r_bit == c_BIT_LAST))
                  w_state_next = r_par_en ? c_PARITY : c_STOP;
      c_PARITY: if (w_period_end) w_state_next = c_STOP;
      c_STOP:   if (w_period_end) w_state_next = c_IDLE;
      default:  w_state_next = c_IDLE;
    endcase
  end

  // Output logic: line level for the current state, done pulse on the last stop tick
  always_comb begin
    w_tx_next    = 1'b1;
    tx_done_tick = 1'b0;
    case (r_state)
      c_START:  w_tx_next = 1'b0;
      c_DATA:   w_tx_next = r_shreg[0];
      c_PARITY: w_tx_next = r_par_bit;
      c_STOP:   tx_done_tick = w_period_end;
      default:  w_tx_next = 1'b1;
    endcase
  end

  // Registered line driver; reset forces the idle level immediately
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx <= 1'b1;
    end else begin
      r_tx <= w_tx_next;
    end
  end

  // Frame datapath: load/latch config, tick and bit counters, shift register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tick    <= '0;
      r_bit     <= '0;
      r_shreg   <= '0;
      r_par_bit <= 1'b0;
      r_par_en  <= 1'b0;
      r_stop2   <= 1'b0;
    end else if (w_load) begin
      r_shreg   <= w_word;
      r_par_bit <= w_par_calc;
      r_par_en  <= (cfg_par != 2'b00);
      r_stop2   <= cfg_stop2;
      r_tick    <= '0;
      r_bit     <= '0;
    end else if ((r_state != c_IDLE) && s_tick) begin
      if (w_period_end) begin
        r_tick <= '0;
        if (r_state == c_DATA) begin
          r_shreg <= {1'b0, r_shreg[DBIT-1:1]};
          r_bit   <= (r_bit == c_BIT_LAST) ? '0 : r_bit + c_BIT_ONE;
        end
      end else begin
        r_tick <= r_tick + c_TICK_ONE;
      end
    end
  end

  assign tx   = r_tx;
  assign busy = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_cfg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_uart_tx_cfg                                                |
// | Purpose  : Scoreboard bench for uart_tx_cfg. Stimulus pushes expected    |
// |            frames; a monitor decodes tx one level per s_tick and checks. |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_uart_tx_cfg;

  localparam int DBIT       = 8;
  localparam int OVS        = 16;
  localparam int FIFO_DEPTH = 4;

  typedef struct {
    logic [DBIT-1:0] data;
    logic [1:0]      par;
    logic            stop2;
  } frame_t;

  logic            clk       = 1'b0;
  logic            reset_n   = 1'b0;
  logic            s_tick    = 1'b0;
  logic [DBIT-1:0] din       = '0;
  logic            din_valid = 1'b0;
  logic [1:0]      cfg_par   = 2'b00;
  logic            cfg_stop2 = 1'b0;
  logic            din_ready;
  logic            tx;
  logic            busy;
  logic            tx_done_tick;

  frame_t exp_q[$];
  int     n_tests  = 0;
  int     n_fail   = 0;
  int     tick_div = 1;
  int     n_done   = 0;
  int     n_frames = 0;
  bit     mon_in_frame = 0;

  uart_tx_cfg #(.DBIT(DBIT), .OVS(OVS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .din(din),
    .din_valid(din_valid), .din_ready(din_ready), .cfg_par(cfg_par),
    .cfg_stop2(cfg_stop2), .tx(tx), .busy(busy), .tx_done_tick(tx_done_tick)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endfunction

  // s_tick: one clk wide every tick_div clks, held low when tick_div is 0
  initial begin : tick_gen
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (tick_div == 0) begin
        s_tick = 1'b0;
      end else begin
        cnt    = (cnt + 1 >= tick_div) ? 0 : cnt + 1;
        s_tick = (cnt == 0);
      end
    end
  end

  // Monitor: the tx level after a ticked edge belongs to the state that counted that tick
  initial begin : monitor
    logic   prev_tick;
    bit     junk;
    int     cnt, n_samp, first_bad;
    logic   lv[$];
    frame_t cur;
    prev_tick = 1'b0;
    junk = 0; cnt = 0; n_samp = 0; first_bad = -1;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        mon_in_frame = 0;
        junk         = 0;
        prev_tick    = 1'b0;
      end else begin
        if (prev_tick) begin
          if (!mon_in_frame && !junk && tx == 1'b0) begin
            check("frame_expected_pending", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
              cur = exp_q.pop_front();
              lv.delete();
              lv.push_back(1'b0);
              for (int i = 0; i < DBIT; i++) lv.push_back(cur.data[i]);
              case (cur.par)
                2'b01: lv.push_back(^cur.data);
                2'b10: lv.push_back(~^cur.data);
                2'b11: lv.push_back(1'b1);
                default: ;
              endcase
              lv.push_back(1'b1);
              if (cur.stop2) lv.push_back(1'b1);
              n_samp       = lv.size() * OVS;
              cnt          = 0;
              first_bad    = -1;
              mon_in_frame = 1;
            end else begin
              junk = 1;
            end
          end
          if (mon_in_frame) begin
            if (tx !== lv[cnt / OVS] && first_bad < 0) first_bad = cnt;
            cnt++;
            if (cnt == n_samp) begin
              check($sformatf("frame_%02h_first_bad_tick", cur.data), first_bad, -1);
              n_frames++;
              mon_in_frame = 0;
            end
          end
        end
        if (tx_done_tick) begin
          n_done++;
          if (junk) junk = 0;
          else check("done_tick_position", mon_in_frame ? cnt : -1, n_samp - 1);
        end
        prev_tick = s_tick;
      end
    end
  end

  initial begin : watchdog
    #700000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [DBIT-1:0] d, input logic [1:0] p, input logic s2);
    frame_t f;
    int     guard;
    guard = 0;
    @(negedge clk);
    while (!din_ready && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    check("send_ready_wait", din_ready, 1);
    din = d; cfg_par = p; cfg_stop2 = s2; din_valid = 1'b1;
    f.data = d; f.par = p; f.stop2 = s2;
    exp_q.push_back(f);
    @(posedge clk);
    #1;
    din_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_clk);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || exp_q.size() != 0 || mon_in_frame) && n < max_clk);
    check("idle_wait_in_budget", n < max_clk, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_tx(input logic v, input int max_clk);
    int n;
    n = 0;
    @(negedge clk);
    while (tx !== v && n < max_clk) begin
      @(negedge clk);
      n++;
    end
    check("tx_level_wait", tx, v);
  endtask

  logic [7:0] words [6];
  int         n, changes, done0;
  logic       t0, b0;

  initial begin
    words = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    check("reset_done", tx_done_tick, 0);
    check("reset_din_ready", din_ready, 1);
    @(posedge clk); #1 reset_n = 1'b1;

    // 0x55, no parity, one stop, tick every clk
    tick_div = 1;
    send(8'h55, 2'b00, 1'b0);
`ifndef UART_TX_FIFO_EN
    check("start_entry_busy", busy, 1);
    check("start_entry_tx_still_idle", tx, 1);
    check("busy_ready_low", din_ready, 0);
    @(posedge clk); #1;
    check("start_tx_low", tx, 0);
`endif
    wait_idle(400);

    // 0x07 with each parity mode; din and config scrambled mid-frame
    for (int p = 1; p < 4; p++) begin
      send(8'h07, 2'(p), 1'b0);
      repeat (40) @(negedge clk);
      din = 8'h0F; cfg_par = 2'(3 - p); cfg_stop2 = 1'b1;
      wait_idle(400);
    end

    // Two stop bits; toggle stop/parity config during DATA
    send(8'hA3, 2'b00, 1'b1);
    repeat (50) @(negedge clk);
    cfg_stop2 = 1'b0; cfg_par = 2'b11;
    repeat (20) @(negedge clk);
    cfg_par = 2'b01;
    wait_idle(400);

    // Slow tick: bits 1..2 of 0x96 are both 1, so that run is two bit periods
    tick_div = 10;
    send(8'h96, 2'b10, 1'b0);
    wait_tx(1'b0, 3000);
    wait_tx(1'b1, 3000);
    n = 0;
    while (tx === 1'b1 && n < 1000) begin
      n++;
      @(negedge clk);
    end
    check("slow_two_bit_run_clks", n, 320);
    repeat (50) @(negedge clk);
    tick_div = 0;
    repeat (12) @(negedge clk);
    t0 = tx; b0 = busy; changes = 0;
    repeat (500) begin
      @(negedge clk);
      if (tx !== t0 || busy !== b0) changes++;
    end
    check("stall_busy_held", b0, 1);
    check("stall_changes", changes, 0);
    tick_div = 10;
    wait_idle(5000);

    // Asynchronous reset during data bit 3
    tick_div = 1;
    send(8'h3C, 2'b01, 1'b0);
`ifdef UART_TX_FIFO_EN
    send(8'hC3, 2'b01, 1'b0);
`endif
    wait_tx(1'b0, 100);
    repeat (72) @(negedge clk);
    @(posedge clk); #3;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check("async_reset_tx", tx, 1);
    check("async_reset_busy", busy, 0);
    check("async_reset_done", tx_done_tick, 0);
    repeat (2) @(negedge clk);
    check("reset_ready_again", din_ready, 1);
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (100) @(negedge clk);
    check("no_frame_after_reset", busy, 0);
    send(8'h5A, 2'b10, 1'b1);
    wait_idle(400);

`ifdef UART_TX_FIFO_EN
    // Six words with din_valid held: five accepted at once, the sixth waits
    done0 = n_done;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      din = words[k]; cfg_par = 2'b01; cfg_stop2 = 1'b0; din_valid = 1'b1;
      check($sformatf("fifo_ready_word%0d", k + 1), din_ready, (k < 5) ? 1 : 0);
      n = 0;
      while (!din_ready && n < 2000) begin
        @(negedge clk);
        n++;
      end
      begin
        frame_t f;
        f.data = words[k]; f.par = 2'b01; f.stop2 = 1'b0;
        exp_q.push_back(f);
      end
      @(posedge clk);
    end
    @(negedge clk);
    din_valid = 1'b0;
    wait_idle(3000);
    check("fifo_done_pulses", n_done - done0, 6);
`endif

    check("done_count_vs_frames", n_done, n_frames);
    check("queue_empty_at_end", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
